// File: rtl/uart_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_frame_ctrl
// Receive-side frame controller placed directly behind a UART receiver.
// Builds length-prefixed, checksummed command frames from the byte stream:
//     SYNC_BYTE, LEN, LEN payload bytes, CSUM
// CSUM is chosen so that (LEN + payload + CSUM) mod 256 == 0.
// A good payload is held in an internal buffer until the host acknowledges it.
//
// Ports
//   clk          in   system clock (same clock as the UART receiver)
//   reset        in   synchronous, active-high reset
//   rx_data      in   received byte, valid while rx_available = 1
//   rx_available in   single-cycle strobe: a new byte has arrived
//   rx_idle      in   level: the line has been idle long enough to time out
//   frame_valid  out  single-cycle pulse: a good frame is now held
//   frame_error  out  single-cycle pulse: frame discarded or byte dropped
//   err_code     out  error cause: 00 overrun, 01 length, 10 checksum, 11 timeout
//   frame_len    out  payload length of the held frame
//   rd_addr      in   buffer read index
//   rd_data      out  buffer[rd_addr], registered (one-cycle latency)
//   frame_ack    in   host has finished with the held frame
//   busy_hold    out  high while a good frame is held
// ---------------------------------------------------------------------------
module uart_frame_ctrl #(
    parameter int          MAX_LEN   = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hAA
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_available,
    input  logic                         rx_idle,
    output logic                         frame_valid,
    output logic                         frame_error,
    output logic [1:0]                   err_code,
    output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
    input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
    output logic [7:0]                   rd_data,
    input  logic                         frame_ack,
    output logic                         busy_hold
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int PW = $clog2(MAX_LEN);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_CSUM    = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;

    localparam logic [1:0] E_OVERRUN = 2'b00;
    localparam logic [1:0] E_LENGTH  = 2'b01;
    localparam logic [1:0] E_CSUM    = 2'b10;
    localparam logic [1:0] E_TIMEOUT = 2'b11;

    localparam logic [8:0] MAX_LEN9 = 9'(MAX_LEN);

    logic [2:0]    r_state;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_cnt;
    logic [PW-1:0] r_ptr;
    logic [7:0]    r_acc;
    logic          r_frame_valid;
    logic          r_frame_error;
    logic [1:0]    r_err_code;
    logic [LW-1:0] r_frame_len;
    logic          r_busy_hold;
    logic [7:0]    r_rd_data;
    logic [7:0]    r_buf [MAX_LEN];

    logic [2:0]    w_next_state;
    logic          w_valid;
    logic          w_error;
    logic [1:0]    w_code;
    logic          w_wr_en;
    logic          w_len_load;
    logic [8:0]    w_byte9;
    logic [7:0]    w_sum;

    assign w_byte9 = {1'b0, rx_data};
    assign w_sum   = r_acc + rx_data;

    // Next-state, error and buffer-write decisions for the current cycle
    always_comb begin
        w_next_state = r_state;
        w_valid      = 1'b0;
        w_error      = 1'b0;
        w_code       = E_OVERRUN;
        w_wr_en      = 1'b0;
        w_len_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_available && (rx_data == SYNC_BYTE)) begin
                    w_next_state = S_LEN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LEN: begin
                if (rx_available) begin
                    if ((rx_data == 8'h00) || (w_byte9 > MAX_LEN9)) begin
                        w_error      = 1'b1;
                        w_code       = E_LENGTH;
                        w_next_state = S_IDLE;
                    end else begin
                        w_len_load   = 1'b1;
                        w_next_state = S_PAYLOAD;
                    end
                end else if (rx_idle) begin
                    w_error      = 1'b1;
                    w_code       = E_TIMEOUT;
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_LEN;
                end
            end
            S_PAYLOAD: begin
                if (rx_available) begin
                    w_wr_en = 1'b1;
                    // r_cnt still holds the count before this byte
                    if (r_cnt == LW'(1)) begin
                        w_next_state = S_CSUM;
                    end else begin
                        w_next_state = S_PAYLOAD;
                    end
                end else if (rx_idle) begin
                    w_error      = 1'b1;
                    w_code       = E_TIMEOUT;
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_PAYLOAD;
                end
            end
            S_CSUM: begin
                if (rx_available) begin
                    if (w_sum == 8'h00) begin
                        w_valid      = 1'b1;
                        w_next_state = S_HOLD;
                    end else begin
                        w_error      = 1'b1;
                        w_code       = E_CSUM;
                        w_next_state = S_IDLE;
                    end
                end else if (rx_idle) begin
                    w_error      = 1'b1;
                    w_code       = E_TIMEOUT;
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_CSUM;
                end
            end
            S_HOLD: begin
                if (frame_ack) begin
                    // A byte arriving with the ack is judged under IDLE rules
                    if (rx_available && (rx_data == SYNC_BYTE)) begin
                        w_next_state = S_LEN;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else if (rx_available) begin
                    w_error      = 1'b1;
                    w_code       = E_OVERRUN;
                    w_next_state = S_HOLD;
                end else begin
                    w_next_state = S_HOLD;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Control state, counters, accumulator and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_cnt         <= '0;
            r_ptr         <= '0;
            r_acc         <= 8'h00;
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;
            r_err_code    <= 2'b00;
            r_frame_len   <= '0;
            r_busy_hold   <= 1'b0;
            r_rd_data     <= 8'h00;
        end else begin
            r_state       <= w_next_state;
            r_frame_valid <= w_valid;
            r_frame_error <= w_error;
            r_err_code    <= w_error ? w_code : 2'b00;
            r_busy_hold   <= (w_next_state == S_HOLD);
            r_rd_data     <= r_buf[rd_addr];
            if (w_len_load) begin
                r_len <= w_byte9[LW-1:0];
                r_cnt <= w_byte9[LW-1:0];
                r_ptr <= '0;
                r_acc <= rx_data;
            end else if (w_wr_en) begin
                r_cnt <= r_cnt - LW'(1);
                r_ptr <= r_ptr + PW'(1);
                r_acc <= w_sum;
            end else begin
                r_cnt <= r_cnt;
                r_ptr <= r_ptr;
                r_acc <= r_acc;
            end
            if (w_valid) begin
                r_frame_len <= r_len;
            end else begin
                r_frame_len <= r_frame_len;
            end
        end
    end

    // Payload buffer; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[r_ptr] <= rx_data;
        end
    end

    assign frame_valid = r_frame_valid;
    assign frame_error = r_frame_error;
    assign err_code    = r_err_code;
    assign frame_len   = r_frame_len;
    assign busy_hold   = r_busy_hold;
    assign rd_data     = r_rd_data;

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
- Receive-side frame controller that sits directly behind the UART receiver.
- Consumes the receiver's byte stream (rx_data, rx_available strobe, rx_idle level) and sequences it into length-prefixed, checksummed command frames.
- Stores each payload in an internal buffer and holds it for the host logic until acknowledged.
- Reports framing errors: bad length, bad checksum, inter-byte timeout, overrun.

Parameters:
- MAX_LEN, 16: maximum payload bytes per frame. Buffer depth; power of two; 2..256.
- SYNC_BYTE, 8'hAA: start-of-frame marker.

Ports:
- clk  in  1  system clock, the same clock the UART receiver runs on.
- reset  in  1  synchronous, active-high.
- rx_data  in  8  byte from the receiver. Valid only in the cycle rx_available is high.
- rx_available  in  1  single-cycle strobe: a byte with a valid stop bit has arrived.
- rx_idle  in  1  level: the line has been idle at least 16 oversample ticks.
- frame_valid  out  1  single-cycle pulse: a good frame is now held in the buffer.
- frame_error  out  1  single-cycle pulse: a frame was discarded or a byte was dropped.
- err_code  out  2  cause of the error, valid with frame_error:
  - 00 overrun
  - 01 bad length
  - 10 checksum
  - 11 timeout
- frame_len  out  $clog2(MAX_LEN+1)  payload length of the held frame. Valid while busy_hold=1.
- rd_addr  in  $clog2(MAX_LEN)  buffer read index.
- rd_data  out  8  buffer[rd_addr], registered, one-cycle latency.
- frame_ack  in  1  host has finished with the held frame; releases the buffer.
- busy_hold  out  1  high while a good frame is held (state HOLD).

Behaviour:
- Frame format, in order:
  - SYNC_BYTE
  - LEN
  - LEN payload bytes
  - CSUM, chosen so that (LEN + payload bytes + CSUM) mod 256 == 0
- Arithmetic: the running sum is an 8-bit accumulator, wrap-around. The payload write pointer is $clog2(MAX_LEN) bits. A byte counter counts down from LEN.
- Reset state: all outputs 0, state IDLE, accumulator 0, rd_data 0. Buffer contents are undefined after reset.
- Events below are evaluated only in cycles with rx_available=1, except the timeout and ack rules.
- IDLE:
  - byte == SYNC_BYTE -> LEN.
  - Any other byte is silently discarded.
- LEN:
  - byte == 0 or byte > MAX_LEN -> frame_error, err_code=01, then IDLE.
  - Otherwise latch LEN, accumulator <= byte, pointer <= 0, go to PAYLOAD.
- PAYLOAD:
  - Write byte to buffer[pointer], pointer++, accumulator += byte.
  - After the LEN-th byte -> CSUM.
- CSUM:
  - (accumulator + byte) mod 256 == 0 -> frame_valid pulse, frame_len <= LEN, go to HOLD.
  - Otherwise frame_error, err_code=10, then IDLE.
- Timing: frame_valid and frame_error assert in the cycle after the triggering rx_available strobe, for exactly one cycle.
- Timeout:
  - In LEN, PAYLOAD or CSUM, rx_idle=1 with rx_available=0 -> frame_error, err_code=11, then IDLE.
  - If rx_available=1 in the same cycle, the byte is processed and the timeout is ignored for that cycle.
  - rx_idle is ignored in IDLE and HOLD.
- HOLD:
  - The buffer and frame_len are frozen and busy_hold=1. The host reads via rd_addr/rd_data.
  - An incoming byte without frame_ack -> byte dropped, frame_error, err_code=00, remain in HOLD.
  - frame_ack=1 -> go to IDLE next cycle.
  - frame_ack and rx_available in the same cycle -> the byte is evaluated under IDLE rules. A SYNC_BYTE therefore moves directly to LEN and no overrun is flagged.
- frame_ack outside HOLD is ignored.
- A SYNC_BYTE value inside LEN, PAYLOAD or CSUM is treated as ordinary data; there is no resync.
- Reset asserted mid-frame:
  - Returns to IDLE next cycle.
  - Clears pulses, busy_hold and frame_len.
  - A partially received frame is discarded without an error.
- rd_data reads are permitted in any state. Reads outside HOLD return buffer contents with no guarantee of consistency.

Test Plan:
- Good frame: bytes AA 03 11 22 33 97 -> one frame_valid pulse, frame_len=3, busy_hold=1. Reading rd_addr 0,1,2 returns 11,22,33 one cycle later. frame_ack -> busy_hold=0.
- Length errors: AA 00 -> frame_error, err_code=01, IDLE. AA 11 with MAX_LEN=16 -> err_code=01. Noise bytes 55 00 before AA are ignored with no error.
- Checksum error: AA 02 01 02 00 -> frame_error, err_code=10, no frame_valid. A following good frame AA 01 FF 00 -> frame_valid, frame_len=1, rd_data[0]=FF.
- Timeout: AA 04 10 20, then rx_idle=1 -> frame_error, err_code=11. Also drive rx_idle and rx_available in the same cycle -> the byte is accepted and no timeout fires.
- Overrun and ack race: hold a frame, send byte 5A -> err_code=00, held buffer unchanged. Then frame_ack coincident with AA followed by 01 7F 80 -> no error, a second frame_valid, frame_len=1.
- Reset mid-frame: AA 03 11, then reset for one cycle -> all outputs 0, no pulses. The next AA 01 05 FA -> frame_valid.
